// File: rtl/sdram_init_refresh_pkg.sv
// Shared SDRAM command encodings, address constants and default timing values.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sdram_init_refresh_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    typedef enum logic [3:0] {
        CMD_LMR  = 4'b0000,
        CMD_REF  = 4'b0001,
        CMD_PRE  = 4'b0010,
        CMD_NOP  = 4'b0111,
        CMD_DESL = 4'b1111
    } sdram_cmd_e;

    // A10 high on PRECHARGE selects all banks
    localparam logic [11:0] A10_ALL_BANKS = 12'h400;

    localparam int          DEF_INIT_WAIT  = 10000;
    localparam int          DEF_T_RP       = 2;
    localparam int          DEF_T_RFC      = 7;
    localparam int          DEF_T_MRD      = 2;
    localparam int          DEF_REF_PERIOD = 780;
    localparam logic [11:0] DEF_MODE_REG   = 12'h033;

    typedef enum logic [3:0] {
        ST_PWRUP,
        ST_INIT_WAIT,
        ST_INIT_PRE,
        ST_INIT_REF1,
        ST_INIT_REF2,
        ST_INIT_LMR,
        ST_IDLE,
        ST_REF_PRE,
        ST_REF_REF
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sdram_init_refresh_if.sv
// Command bus and refresh req/gnt handshake between the init/refresh stage and its neighbours.
// Latency: n/a (wiring only).
// Backpressure: ref_req/ref_gnt handshake; ref_busy marks ownership of the command bus.
interface sdram_init_refresh_if;
    logic        ref_gnt;
    logic        init_done;
    logic        ref_req;
    logic        ref_busy;
    logic        ref_overrun;
    logic        cke;
    logic        cs_n;
    logic        ras_n;
    logic        cas_n;
    logic        we_n;
    logic [11:0] addr;
    logic [1:0]  bank;

    modport master (
        input  ref_gnt,
        output init_done, ref_req, ref_busy, ref_overrun,
        output cke, cs_n, ras_n, cas_n, we_n, addr, bank
    );

    modport slave (
        output ref_gnt,
        input  init_done, ref_req, ref_busy, ref_overrun,
        input  cke, cs_n, ras_n, cas_n, we_n, addr, bank
    );
endinterface

// File: rtl/sdram_cmd_timer.sv
// Loadable down-counter with zero flag; holds at zero until reloaded.
// Latency: load takes effect on the next edge; zero is combinational from the count.
// Backpressure: none.
module sdram_cmd_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;

    // Load has priority; otherwise count down and park at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/sdram_init_refresh.sv
// SDRAM power-up sequencer and periodic AUTO REFRESH scheduler; build option SDRAM_REF_DEBT_EN.
// Latency: commands registered, one cycle after the deciding edge; gaps filled with NOP.
// Backpressure: refresh waits in IDLE with ref_req high until ref_gnt; owed refreshes are counted.
module sdram_init_refresh
    import sdram_init_refresh_pkg::*;
#(
    parameter int          INIT_WAIT  = DEF_INIT_WAIT,
    parameter int          T_RP       = DEF_T_RP,
    parameter int          T_RFC      = DEF_T_RFC,
    parameter int          T_MRD      = DEF_T_MRD,
    parameter int          REF_PERIOD = DEF_REF_PERIOD,
    parameter logic [11:0] MODE_REG   = DEF_MODE_REG
) (
    input  logic                clk,
    input  logic                rst_n,
    sdram_init_refresh_if.master bus
);
    localparam int TMAX = max_int(max_int(INIT_WAIT, REF_PERIOD),
                                  max_int(max_int(T_RP, T_RFC), T_MRD));
    localparam int TW = $clog2(TMAX + 1);

    // A wait of T cycles loads T-1: the timer reaches zero T-1 edges later
    // and the following edge issues the next command.
    localparam logic [TW-1:0] LD_INIT = TW'(INIT_WAIT - 1);
    localparam logic [TW-1:0] LD_RP   = TW'(T_RP - 1);
    localparam logic [TW-1:0] LD_RFC  = TW'(T_RFC - 1);
    localparam logic [TW-1:0] LD_MRD  = TW'(T_MRD - 1);
    localparam logic [TW-1:0] LD_REF  = TW'(REF_PERIOD - 1);

    state_e        state_q, state_d;
    logic [3:0]    cmd_q, cmd_d;
    logic [11:0]   addr_q, addr_d;
    logic          cke_q;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          wt_load;
    logic [TW-1:0] wt_val;
    logic          wt_zero;
    logic          rt_load;
    logic          rt_zero;
    logic          expire;
    logic          ref_issue;
    logic          pending;
    logic          ref_req_w;

    sdram_cmd_timer #(.W(TW)) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (wt_load),
        .load_val (wt_val),
        .zero     (wt_zero)
    );

    // Refresh interval: held at full period until init completes, then free-runs
    assign rt_load = !done_q || rt_zero;
    assign expire  = done_q && rt_zero;

    sdram_cmd_timer #(.W(TW)) u_ref_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (rt_load),
        .load_val (LD_REF),
        .zero     (rt_zero)
    );

`ifdef SDRAM_REF_DEBT_EN
    logic [2:0] debt_q, debt_d;

    // Owed refreshes: +1 per expiry (saturating), -1 per REF issued
    always_comb begin
        debt_d = debt_q;
        if (expire && !ref_issue) begin
            debt_d = (debt_q == 3'd7) ? 3'd7 : debt_q + 3'd1;
        end else if (!expire && ref_issue && debt_q != 3'd0) begin
            debt_d = debt_q - 3'd1;
        end
    end

    // Debt register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            debt_q <= 3'd0;
        end else begin
            debt_q <= debt_d;
        end
    end

    assign pending         = (debt_q != 3'd0);
    assign bus.ref_overrun = 1'b0;
`else
    logic pending_q;
    logic overrun_q;

    // Single pending bit; expiry wins over a same-edge REF so no interval is lost.
    // A second expiry while still pending is a missed refresh and latches overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (expire) begin
                pending_q <= 1'b1;
            end else if (ref_issue) begin
                pending_q <= 1'b0;
            end
            if (expire && pending_q && !ref_issue) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign pending         = pending_q;
    assign bus.ref_overrun = overrun_q;
`endif

    assign ref_req_w = pending && (state_q == ST_IDLE);

    // Next state, next command and wait-timer reloads
    always_comb begin
        state_d   = state_q;
        cmd_d     = CMD_NOP;
        addr_d    = '0;
        done_d    = done_q;
        busy_d    = busy_q;
        wt_load   = 1'b0;
        wt_val    = '0;
        ref_issue = 1'b0;
        case (state_q)
            ST_PWRUP: begin
                state_d = ST_INIT_WAIT;
                wt_load = 1'b1;
                wt_val  = LD_INIT;
            end
            ST_INIT_WAIT: begin
                if (wt_zero) begin
                    cmd_d   = CMD_PRE;
                    addr_d  = A10_ALL_BANKS;
                    wt_load = 1'b1;
                    wt_val  = LD_RP;
                    state_d = ST_INIT_PRE;
                end
            end
            ST_INIT_PRE: begin
                if (wt_zero) begin
                    cmd_d   = CMD_REF;
                    wt_load = 1'b1;
                    wt_val  = LD_RFC;
                    state_d = ST_INIT_REF1;
                end
            end
            ST_INIT_REF1: begin
                if (wt_zero) begin
                    cmd_d   = CMD_REF;
                    wt_load = 1'b1;
                    wt_val  = LD_RFC;
                    state_d = ST_INIT_REF2;
                end
            end
            ST_INIT_REF2: begin
                if (wt_zero) begin
                    cmd_d   = CMD_LMR;
                    addr_d  = MODE_REG;
                    wt_load = 1'b1;
                    wt_val  = LD_MRD;
                    state_d = ST_INIT_LMR;
                end
            end
            ST_INIT_LMR: begin
                if (wt_zero) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (ref_req_w && bus.ref_gnt) begin
                    cmd_d   = CMD_PRE;
                    addr_d  = A10_ALL_BANKS;
                    busy_d  = 1'b1;
                    wt_load = 1'b1;
                    wt_val  = LD_RP;
                    state_d = ST_REF_PRE;
                end
            end
            ST_REF_PRE: begin
                if (wt_zero) begin
                    cmd_d     = CMD_REF;
                    ref_issue = 1'b1;
                    wt_load   = 1'b1;
                    wt_val    = LD_RFC;
                    state_d   = ST_REF_REF;
                end
            end
            ST_REF_REF: begin
                if (wt_zero) begin
`ifdef SDRAM_REF_DEBT_EN
                    if (pending) begin
                        cmd_d     = CMD_REF;
                        ref_issue = 1'b1;
                        wt_load   = 1'b1;
                        wt_val    = LD_RFC;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
`else
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
`endif
                end
            end
            default: begin
                state_d = ST_PWRUP;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_PWRUP;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered command bus and status; cke rises on the first edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cke_q  <= 1'b0;
            cmd_q  <= CMD_DESL;
            addr_q <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b1;
        end else begin
            cke_q  <= 1'b1;
            cmd_q  <= cmd_d;
            addr_q <= addr_d;
            done_q <= done_d;
            busy_q <= busy_d;
        end
    end

    assign bus.cke       = cke_q;
    assign {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n} = cmd_q;
    assign bus.addr      = addr_q;
    assign bus.bank      = 2'b00;
    assign bus.init_done = done_q;
    assign bus.ref_busy  = busy_q;
    assign bus.ref_req   = ref_req_w;
endmodule

// File: tb/tb_sdram_init_refresh.sv
// Bench for sdram_init_refresh: init sequence, granted/blocked refresh, mid-refresh reset, ignored grants.
// Latency: commands checked against absolute cycle numbers counted from reset release.
// Backpressure: ref_gnt driven directly by the stimulus.
module tb_sdram_init_refresh;
    import sdram_init_refresh_pkg::*;

    typedef struct {
        int          cyc;
        logic [3:0]  cmd;
        logic [11:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [3:0] mon_cmd;
    int   busy_fall;

    sdram_init_refresh_if bus ();

    sdram_init_refresh #(
        .INIT_WAIT  (20),
        .T_RP       (2),
        .T_RFC      (3),
        .T_MRD      (2),
        .REF_PERIOD (40),
        .MODE_REG   (12'h033)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Edge count since reset release: edge k leaves cyc == k
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total_cnt++;
        assert (obs === exp_v) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, exp_v, cyc);
    endtask

    task automatic push(input int c, input logic [3:0] cmd, input logic [11:0] addr);
        exp_t e;
        e.cyc  = c;
        e.cmd  = cmd;
        e.addr = addr;
        exp_q.push_back(e);
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push_init;
        push(21, CMD_PRE, 12'h400);
        push(23, CMD_REF, 12'h000);
        push(26, CMD_REF, 12'h000);
        push(29, CMD_LMR, 12'h033);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cke"},   32'(bus.cke), 32'd0);
        check({tag, "_cmd"},   32'({bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n}), 32'hF);
        check({tag, "_addr"},  32'(bus.addr), 32'd0);
        check({tag, "_bank"},  32'(bus.bank), 32'd0);
        check({tag, "_done"},  32'(bus.init_done), 32'd0);
        check({tag, "_req"},   32'(bus.ref_req), 32'd0);
        check({tag, "_busy"},  32'(bus.ref_busy), 32'd1);
    endtask

    task automatic release_reset;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Scoreboard: every non-NOP command must match the next expected entry
    always @(negedge clk) begin
        if (rst_n && cyc >= 1) begin
            mon_cmd = {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n};
            if (mon_cmd != CMD_NOP) begin
                check("cmd_bank", 32'(bus.bank), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_cmd", 32'(mon_cmd), 32'(CMD_NOP));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("cmd_cyc",  32'(cyc), 32'(mon_e.cyc));
                    check("cmd_code", 32'(mon_cmd), 32'(mon_e.cmd));
                    check("cmd_addr", 32'(bus.addr), 32'(mon_e.addr));
                end
            end
        end
    end

    initial begin
        bus.ref_gnt = 1'b0;

        // Reset values while held in reset
        repeat (3) @(negedge clk);
        check_reset_vals("rst");

        // Phase A: plain init, then grant tied high
        push_init();
        push(72,  CMD_PRE, 12'h400);
        push(74,  CMD_REF, 12'h000);
        push(112, CMD_PRE, 12'h400);
        release_reset();
        wait_to(1);
        check("cke_at_1", 32'(bus.cke), 32'd1);
        check("nop_at_1", 32'({bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n}), 32'(CMD_NOP));
        wait_to(30);
        check("done_at_30", 32'(bus.init_done), 32'd0);
        check("busy_at_30", 32'(bus.ref_busy), 32'd1);
        wait_to(31);
        check("done_at_31", 32'(bus.init_done), 32'd1);
        check("busy_at_31", 32'(bus.ref_busy), 32'd0);
        check("req_at_31",  32'(bus.ref_req), 32'd0);
        wait_to(35);
        bus.ref_gnt = 1'b1;
        wait_to(70);
        check("req_at_70", 32'(bus.ref_req), 32'd0);
        wait_to(71);
        check("req_at_71", 32'(bus.ref_req), 32'd1);
        wait_to(72);
        check("req_at_72",  32'(bus.ref_req), 32'd0);
        check("busy_at_72", 32'(bus.ref_busy), 32'd1);
        wait_to(76);
        check("busy_at_76", 32'(bus.ref_busy), 32'd1);
        wait_to(77);
        check("busy_at_77", 32'(bus.ref_busy), 32'd0);
        wait_to(111);
        check("req_at_111", 32'(bus.ref_req), 32'd1);
        wait_to(113);
        check("busy_mid_ref", 32'(bus.ref_busy), 32'd1);
        check("queue_a", 32'(exp_q.size()), 32'd0);

        // Reset between refresh PRE and REF: outputs drop immediately
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        bus.ref_gnt = 1'b0;
        repeat (2) @(negedge clk);

        // Phase B: grant pulses during init and with nothing pending, then grant withheld
        push_init();
        release_reset();
        wait_to(5);  bus.ref_gnt = 1'b1; @(negedge clk); bus.ref_gnt = 1'b0;
        wait_to(21); bus.ref_gnt = 1'b1; @(negedge clk); bus.ref_gnt = 1'b0;
        wait_to(24); bus.ref_gnt = 1'b1; @(negedge clk); bus.ref_gnt = 1'b0;
        wait_to(29); bus.ref_gnt = 1'b1; @(negedge clk); bus.ref_gnt = 1'b0;
        wait_to(31);
        check("b_done_at_31", 32'(bus.init_done), 32'd1);
        wait_to(50); bus.ref_gnt = 1'b1; @(negedge clk); bus.ref_gnt = 1'b0;
        wait_to(71);
        check("b_req_at_71", 32'(bus.ref_req), 32'd1);
        wait_to(100);
        check("b_req_at_100", 32'(bus.ref_req), 32'd1);
        wait_to(110);
        check("ovr_at_110", 32'(bus.ref_overrun), 32'd0);
        wait_to(111);
`ifdef SDRAM_REF_DEBT_EN
        check("ovr_at_111", 32'(bus.ref_overrun), 32'd0);
`else
        check("ovr_at_111", 32'(bus.ref_overrun), 32'd1);
`endif
        wait_to(131);
        check("b_req_at_131",  32'(bus.ref_req), 32'd1);
        check("b_busy_at_131", 32'(bus.ref_busy), 32'd0);
        check("queue_b_init",  32'(exp_q.size()), 32'd0);
        push(132, CMD_PRE, 12'h400);
        push(134, CMD_REF, 12'h000);
`ifdef SDRAM_REF_DEBT_EN
        push(137, CMD_REF, 12'h000);
        busy_fall = 140;
`else
        busy_fall = 137;
`endif
        bus.ref_gnt = 1'b1;
        wait_to(132);
        check("b_req_at_132",  32'(bus.ref_req), 32'd0);
        check("b_busy_at_132", 32'(bus.ref_busy), 32'd1);
        wait_to(busy_fall - 1);
        check("b_busy_before_fall", 32'(bus.ref_busy), 32'd1);
        wait_to(busy_fall);
        check("b_busy_fall", 32'(bus.ref_busy), 32'd0);
        wait_to(145);
        check("queue_b", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
